// File: rtl/sdi_pkg.sv
// Shared definitions for the SDI receive lock controller: lock-state encoding,
// default parameter values and measurement widths.
package sdi_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } lock_state_t;

  localparam int DEF_LOCK_FRAMES = 3;
  localparam int DEF_MISS_LIMIT  = 4;
  localparam int DEF_TIMEOUT_CYC = 4096;

  localparam int LEN_W  = 13;
  localparam int LINE_W = 11;

  localparam logic [LEN_W-1:0] LEN_MAX = 13'd8191;

endpackage

// File: rtl/sdi_line_meter.sv
// EAV-to-EAV line length counter, last-line-number capture and frame-start
// detection for the SDI lock controller.
module sdi_line_meter
  import sdi_pkg::*;
(
  input  logic              clk_sdi,
  input  logic              rst_n,
  input  logic              rx_sav,
  input  logic              rx_eav,
  input  logic [LINE_W-1:0] rx_line_number,
  output logic              line_done,
  output logic [LEN_W-1:0]  line_len,
  output logic [LEN_W-1:0]  last_len,
  output logic              frame_start,
  output logic [LINE_W-1:0] frame_len
);

  logic [LEN_W-1:0]  len_cnt;
  logic [LINE_W-1:0] last_line;

  // len_cnt restarts at 1 on each EAV so that it equals the EAV spacing when
  // the next EAV arrives; it sticks at LEN_MAX on very long gaps.
  always_ff @(posedge clk_sdi or negedge rst_n) begin
    if (!rst_n) begin
      len_cnt   <= '0;
      last_len  <= '0;
      last_line <= '0;
    end else begin
      if (rx_eav) begin
        len_cnt  <= 13'd1;
        last_len <= len_cnt;
      end else if (len_cnt != LEN_MAX) begin
        len_cnt <= len_cnt + 13'd1;
      end
      if (rx_sav) begin
        last_line <= rx_line_number;
      end
    end
  end

  assign line_done   = rx_eav;
  assign line_len    = len_cnt;
  assign frame_start = rx_sav && (rx_line_number == 11'd1);
  assign frame_len   = last_line;

endmodule

// File: rtl/sdi_rx_lock_ctrl.sv
// SDI receive format lock FSM (SEARCH / MEASURE / LOCKED) with frame-aligned
// video enable. Define SDI_LOCK_WATCHDOG_EN to enable the missing-EAV watchdog.
module sdi_rx_lock_ctrl
  import sdi_pkg::*;
#(
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES,
  parameter int MISS_LIMIT  = DEF_MISS_LIMIT,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk_sdi,
  input  logic              rst_n,
  input  logic              rx_trs,
  input  logic              rx_sav,
  input  logic              rx_eav,
  input  logic [LINE_W-1:0] rx_line_number,
  output logic              fmt_locked,
  output logic              vid_out_en,
  output logic [LEN_W-1:0]  line_words,
  output logic [LINE_W-1:0] frame_lines,
  output logic [7:0]        err_cnt,
  output logic [1:0]        lock_state,
  output logic              timeout
);

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_FRAMES - 1);
  localparam logic [7:0] MISS_LAST = 8'(MISS_LIMIT - 1);

  lock_state_t       state;
  logic [7:0]        frame_count;
  logic              frame_seen;
  logic [7:0]        miss_cnt;

  logic              line_done;
  logic [LEN_W-1:0]  line_len;
  logic [LEN_W-1:0]  last_len;
  logic              frame_start;
  logic [LINE_W-1:0] frame_len;
  logic              line_bad;
  logic              frame_bad;

  // The TRS marker is implied by the SAV/EAV pulses themselves.
  logic unused_trs;
  assign unused_trs = rx_trs;

  sdi_line_meter u_meter (
    .clk_sdi        (clk_sdi),
    .rst_n          (rst_n),
    .rx_sav         (rx_sav),
    .rx_eav         (rx_eav),
    .rx_line_number (rx_line_number),
    .line_done      (line_done),
    .line_len       (line_len),
    .last_len       (last_len),
    .frame_start    (frame_start),
    .frame_len      (frame_len)
  );

  assign line_bad  = line_done && (line_len != line_words);
  assign frame_bad = frame_start && (frame_len != frame_lines);

`ifdef SDI_LOCK_WATCHDOG_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_cnt;
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign timeout = 1'b0;
`endif

  // A bad line always takes priority over a frame start arriving on the same
  // cycle; the watchdog, when present, overrides everything else.
  always_ff @(posedge clk_sdi or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SEARCH;
      line_words  <= '0;
      frame_lines <= '0;
      frame_count <= '0;
      frame_seen  <= 1'b0;
      miss_cnt    <= '0;
      err_cnt     <= '0;
      fmt_locked  <= 1'b0;
      vid_out_en  <= 1'b0;
`ifdef SDI_LOCK_WATCHDOG_EN
      wd_cnt      <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_SEARCH: begin
          fmt_locked <= 1'b0;
          vid_out_en <= 1'b0;
          miss_cnt   <= '0;
          if (frame_start) begin
            line_words  <= last_len;
            frame_count <= '0;
            frame_seen  <= 1'b0;
            state       <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (line_bad) begin
            state <= ST_SEARCH;
          end else if (frame_start) begin
            if (!frame_seen) begin
              frame_lines <= frame_len;
              frame_seen  <= 1'b1;
            end else if (frame_len != frame_lines) begin
              state <= ST_SEARCH;
            end else if (frame_count + 8'd1 >= LOCK_LAST) begin
              state      <= ST_LOCKED;
              fmt_locked <= 1'b1;
              miss_cnt   <= '0;
            end else begin
              frame_count <= frame_count + 8'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (line_bad || frame_bad) begin
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
            if (miss_cnt == MISS_LAST) begin
              state      <= ST_SEARCH;
              fmt_locked <= 1'b0;
              vid_out_en <= 1'b0;
            end else begin
              miss_cnt <= miss_cnt + 8'd1;
            end
          end else begin
            if (line_done) begin
              miss_cnt <= '0;
            end
            if (frame_start) begin
              vid_out_en <= 1'b1;
            end
          end
        end
        default: begin
          state      <= ST_SEARCH;
          fmt_locked <= 1'b0;
          vid_out_en <= 1'b0;
        end
      endcase
`ifdef SDI_LOCK_WATCHDOG_EN
      timeout <= 1'b0;
      if ((state == ST_SEARCH) || line_done) begin
        wd_cnt <= '0;
      end else if (wd_cnt == WD_LAST) begin
        wd_cnt     <= '0;
        timeout    <= 1'b1;
        state      <= ST_SEARCH;
        fmt_locked <= 1'b0;
        vid_out_en <= 1'b0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
`endif
    end
  end

  assign lock_state = state;

endmodule

// File: tb/tb_sdi_rx_lock_ctrl.sv
// Directed self-checking bench for sdi_rx_lock_ctrl using short synthetic
// lines (16 cycles) and 5-line frames; honours SDI_LOCK_WATCHDOG_EN.
`timescale 1ns/1ps
module tb_sdi_rx_lock_ctrl;

  localparam int L  = 16;
  localparam int F  = 5;
  localparam int SO = 4;

  logic        clk_sdi;
  logic        rst_n;
  logic        rx_trs;
  logic        rx_sav;
  logic        rx_eav;
  logic [10:0] rx_line_number;
  logic        fmt_locked;
  logic        vid_out_en;
  logic [12:0] line_words;
  logic [10:0] frame_lines;
  logic [7:0]  err_cnt;
  logic [1:0]  lock_state;
  logic        timeout;

  int total;
  int bad;

  logic [1:0] post_eav_state;
  logic       post_eav_vid;
  logic [1:0] post_sav_state;
  logic       post_sav_vid;
  logic [7:0] post_sav_err;

  sdi_rx_lock_ctrl dut (
    .clk_sdi        (clk_sdi),
    .rst_n          (rst_n),
    .rx_trs         (rx_trs),
    .rx_sav         (rx_sav),
    .rx_eav         (rx_eav),
    .rx_line_number (rx_line_number),
    .fmt_locked     (fmt_locked),
    .vid_out_en     (vid_out_en),
    .line_words     (line_words),
    .frame_lines    (frame_lines),
    .err_cnt        (err_cnt),
    .lock_state     (lock_state),
    .timeout        (timeout)
  );

  initial clk_sdi = 1'b0;
  always #5 clk_sdi = ~clk_sdi;

  task automatic tick;
    @(posedge clk_sdi);
    #1;
  endtask

  // One line: EAV on its first cycle, SAV (carrying num) SO cycles later.
  task automatic send_line(input int len, input int num);
    rx_eav = 1'b1; rx_trs = 1'b1;
    tick;
    post_eav_state = lock_state;
    post_eav_vid   = vid_out_en;
    rx_eav = 1'b0; rx_trs = 1'b0;
    for (int i = 1; i < SO; i++) tick;
    rx_sav = 1'b1; rx_trs = 1'b1; rx_line_number = 11'(num);
    tick;
    post_sav_state = lock_state;
    post_sav_vid   = vid_out_en;
    post_sav_err   = err_cnt;
    rx_sav = 1'b0; rx_trs = 1'b0;
    for (int i = SO + 1; i < len; i++) tick;
  endtask

  task automatic send_lines(input int first, input int last);
    for (int n = first; n <= last; n++) send_line(L, n);
  endtask

  task automatic do_reset;
    rx_trs = 1'b0; rx_sav = 1'b0; rx_eav = 1'b0; rx_line_number = '0;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic lock_up;
    do_reset;
    send_line(L, 4);
    send_line(L, 5);
    repeat (4) send_lines(1, F);
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({fmt_locked, vid_out_en, timeout, lock_state} !== 5'd0) begin
      bad++;
      $display("[TB] FAIL reset_async_flags: got %0b want 0", {fmt_locked, vid_out_en, timeout, lock_state});
    end
    tick;
    tick;
    total++;
    if ({line_words, frame_lines, err_cnt} !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_regs: got lw=%0d fl=%0d err=%0d want 0", line_words, frame_lines, err_cnt);
    end
    total++;
    if (lock_state !== 2'd0) begin
      bad++;
      $display("[TB] FAIL reset_state: got %0d want 0", lock_state);
    end
  endtask

  task automatic test_lock;
    do_reset;
    send_line(L, 4);
    send_line(L, 5);
    send_line(L, 1);
    total++;
    if (post_sav_state !== 2'd1) begin
      bad++; $display("[TB] FAIL lock_fs1_state: got %0d want 1", post_sav_state);
    end
    total++;
    if (line_words !== 13'(L)) begin
      bad++; $display("[TB] FAIL lock_line_words: got %0d want %0d", line_words, L);
    end
    send_lines(2, F);
    send_line(L, 1);
    total++;
    if (frame_lines !== 11'(F)) begin
      bad++; $display("[TB] FAIL lock_frame_lines: got %0d want %0d", frame_lines, F);
    end
    send_lines(2, F);
    send_line(L, 1);
    total++;
    if (post_sav_state !== 2'd1) begin
      bad++; $display("[TB] FAIL lock_fs3_state: got %0d want 1", post_sav_state);
    end
    send_lines(2, F);
    send_line(L, 1);
    total++;
    if ({post_sav_state, fmt_locked, post_sav_vid} !== 4'b1010) begin
      bad++; $display("[TB] FAIL lock_fs4: got state=%0d locked=%0b vid=%0b want 2/1/0", post_sav_state, fmt_locked, post_sav_vid);
    end
    send_lines(2, F);
    total++;
    if (vid_out_en !== 1'b0) begin
      bad++; $display("[TB] FAIL lock_vid_early: got %0b want 0", vid_out_en);
    end
    send_line(L, 1);
    total++;
    if (post_sav_vid !== 1'b1) begin
      bad++; $display("[TB] FAIL lock_fs5_vid: got %0b want 1", post_sav_vid);
    end
    send_lines(2, F);
    total++;
    if (err_cnt !== 8'd0) begin
      bad++; $display("[TB] FAIL lock_err: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_measure_mismatch;
    do_reset;
    send_line(L, 4);
    send_line(L, 5);
    send_lines(1, F);
    send_line(L, 1);
    send_line(L, 2);
    send_line(L - 1, 3);
    send_line(L, 4);
    total++;
    if (post_eav_state !== 2'd0) begin
      bad++; $display("[TB] FAIL meas_short_line: got %0d want 0", post_eav_state);
    end
    send_line(L, 5);
    send_line(L, 1);
    total++;
    if ({post_sav_state, line_words} !== {2'd1, 13'(L)}) begin
      bad++; $display("[TB] FAIL meas_reenter: got state=%0d lw=%0d want 1/%0d", post_sav_state, line_words, L);
    end
    send_lines(2, F);
    send_lines(1, F);
    send_line(L, 1);
    total++;
    if (post_sav_state !== 2'd1) begin
      bad++; $display("[TB] FAIL meas_relock_early: got %0d want 1", post_sav_state);
    end
    send_lines(2, F);
    send_line(L, 1);
    total++;
    if (post_sav_state !== 2'd2) begin
      bad++; $display("[TB] FAIL meas_relock: got %0d want 2", post_sav_state);
    end
    send_lines(2, F);
  endtask

  task automatic test_locked_misses;
    send_line(L, 1);
    total++;
    if (post_sav_vid !== 1'b1) begin
      bad++; $display("[TB] FAIL miss_vid_on: got %0b want 1", post_sav_vid);
    end
    send_line(L + 1, 2);
    send_line(L + 1, 3);
    send_line(L + 1, 4);
    send_line(L, 5);
    send_line(L, 1);
    total++;
    if ({post_eav_state, err_cnt} !== {2'd2, 8'd3}) begin
      bad++; $display("[TB] FAIL miss_three: got state=%0d err=%0d want 2/3", post_eav_state, err_cnt);
    end
    for (int n = 2; n <= F; n++) send_line(L + 1, n);
    send_line(L, 1);
    total++;
    if ({post_eav_state, post_eav_vid} !== 3'b000) begin
      bad++; $display("[TB] FAIL miss_four: got state=%0d vid=%0b want 0/0", post_eav_state, post_eav_vid);
    end
    total++;
    if (err_cnt !== 8'd7) begin
      bad++; $display("[TB] FAIL miss_err7: got %0d want 7", err_cnt);
    end
  endtask

  task automatic test_short_frame;
    lock_up;
    send_lines(1, F - 1);
    send_line(L, 1);
    total++;
    if ({post_sav_state, post_sav_err} !== {2'd2, 8'd1}) begin
      bad++; $display("[TB] FAIL short_frame: got state=%0d err=%0d want 2/1", post_sav_state, post_sav_err);
    end
    send_lines(2, F);
    send_line(L, 1);
    total++;
    if ({post_sav_state, err_cnt} !== {2'd2, 8'd1}) begin
      bad++; $display("[TB] FAIL short_frame_after: got state=%0d err=%0d want 2/1", post_sav_state, err_cnt);
    end
    send_lines(2, F);
  endtask

  task automatic test_err_saturation;
    for (int f = 0; f < 90; f++) begin
      send_line(L, 1);
      send_line(L + 1, 2);
      send_line(L + 1, 3);
      send_line(L + 1, 4);
      send_line(L, 5);
    end
    total++;
    if ({lock_state, err_cnt} !== {2'd2, 8'd255}) begin
      bad++; $display("[TB] FAIL err_sat: got state=%0d err=%0d want 2/255", lock_state, err_cnt);
    end
  endtask

  task automatic test_watchdog;
    int fire;
    int pulses;
    fire = 0;
    pulses = 0;
    send_lines(1, F);
    rx_eav = 1'b1; rx_trs = 1'b1;
    tick;
    rx_eav = 1'b0; rx_trs = 1'b0;
    for (int k = 1; k <= 4200; k++) begin
      tick;
      if (timeout === 1'b1) begin
        pulses++;
        if (fire == 0) fire = k;
      end
    end
`ifdef SDI_LOCK_WATCHDOG_EN
    total++;
    if (fire != 4096) begin
      bad++; $display("[TB] FAIL wd_fire_cycle: got %0d want 4096", fire);
    end
    total++;
    if (pulses != 1) begin
      bad++; $display("[TB] FAIL wd_pulse_width: got %0d want 1", pulses);
    end
    total++;
    if (lock_state !== 2'd0) begin
      bad++; $display("[TB] FAIL wd_state: got %0d want 0", lock_state);
    end
`else
    total++;
    if (pulses != 0) begin
      bad++; $display("[TB] FAIL wd_off_pulses: got %0d want 0", pulses);
    end
    total++;
    if ({lock_state, fmt_locked} !== 3'b101) begin
      bad++; $display("[TB] FAIL wd_off_hold: got state=%0d locked=%0b want 2/1", lock_state, fmt_locked);
    end
`endif
  endtask

  task automatic test_len_saturation;
    do_reset;
    rx_eav = 1'b1;
    tick;
    rx_eav = 1'b0;
    repeat (8300) tick;
    send_line(L, 1);
    total++;
    if ({post_sav_state, line_words} !== {2'd1, 13'd8191}) begin
      bad++; $display("[TB] FAIL len_sat: got state=%0d lw=%0d want 1/8191", post_sav_state, line_words);
    end
  endtask

  task automatic test_async_reset;
    lock_up;
    send_line(L, 1);
    total++;
    if ({vid_out_en, line_words} !== {1'b1, 13'(L)}) begin
      bad++; $display("[TB] FAIL async_pre: got vid=%0b lw=%0d want 1/%0d", vid_out_en, line_words, L);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({fmt_locked, vid_out_en, timeout, lock_state, line_words, frame_lines, err_cnt} !== 37'd0) begin
      bad++; $display("[TB] FAIL async_reset: got locked=%0b vid=%0b state=%0d lw=%0d fl=%0d err=%0d want 0",
                      fmt_locked, vid_out_en, lock_state, line_words, frame_lines, err_cnt);
    end
  endtask

  task automatic test_reset_midline;
    tick;
    rst_n = 1'b1;
    repeat (7) tick;
    send_line(L, 3);
    send_line(L, 4);
    send_line(L, 5);
    send_lines(1, F);
    send_lines(1, F);
    send_line(L, 1);
    total++;
    if ({post_sav_state, fmt_locked} !== 3'b010) begin
      bad++; $display("[TB] FAIL midline_fs3: got state=%0d locked=%0b want 1/0", post_sav_state, fmt_locked);
    end
    send_lines(2, F);
    send_line(L, 1);
    total++;
    if (post_sav_state !== 2'd2) begin
      bad++; $display("[TB] FAIL midline_fs4: got %0d want 2", post_sav_state);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    rx_trs = 1'b0;
    rx_sav = 1'b0;
    rx_eav = 1'b0;
    rx_line_number = '0;
    test_reset;
    test_lock;
    test_measure_mismatch;
    test_locked_misses;
    test_short_frame;
    test_err_saturation;
    test_watchdog;
    test_len_saturation;
    test_async_reset;
    test_reset_midline;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
